// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment display blocks.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a.
package seg7_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern (g..a).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a double-buffered 16-bit hex value across a 4-digit common-anode
// display with a blanking guard at the start of every digit slot.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  import seg7_pkg::*;

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_PRE   = PW'(REFRESH_DIV - 2);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic [15:0]   pend_val_q, pend_val_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dp_q, disp_dp_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic          slot_end, frame_end, blank_slot;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [3:0]    lz_blank;
  logic [3:0]    an_one;

  hex_to_seg7 u_dec (
    .nibble (nibble),
    .seg_n  (dec_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      tick_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      tick_q       <= tick_d;
    end
  end

  always_comb begin
    slot_end  = (presc_q == P_LAST);
    frame_end = slot_end && (idx_q == 2'd3);
    presc_d   = slot_end ? '0 : presc_q + 1'b1;
    idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    // Registered one cycle early so the pulse lines up with the boundary cycle.
    tick_d    = (presc_q == P_PRE) && (idx_q == 2'd3);
  end

  // load is a plain strobe with no back-pressure: every asserted cycle is taken.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    if (load && frame_end) begin
      disp_val_d   = value_in;
      disp_dp_d    = dp_in;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end else if (frame_end && pend_valid_q) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    nibble = disp_val_q[3:0];
      2'd1:    nibble = disp_val_q[7:4];
      2'd2:    nibble = disp_val_q[11:8];
      default: nibble = disp_val_q[15:12];
    endcase
    lz_blank[3] = (LZ_SUPPRESS != 0) && (disp_val_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] && (disp_val_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] && (disp_val_q[7:4] == 4'h0);
    lz_blank[0] = 1'b0;
  end

  always_comb begin
    an_one     = 4'b0001 << idx_q;
    blank_slot = (presc_q < P_BLANK);
    an_d       = AN_OFF;
    seg_d      = SEG_OFF;
    if (!blank_slot) begin
      an_d  = ~an_one;
      seg_d = {~disp_dp_q[idx_q], lz_blank[idx_q] ? SEG_BLANK : dec_seg};
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: one instance with leading-zero
// suppression and one without, driven by the same inputs.
module tb_seg7_scan_driver;

  localparam int RDIV = 8;
  localparam int BLK  = 2;
  localparam int NVEC = 9;

  logic        clk;
  logic        rst_n;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic [7:0]  seg_lz, seg_nolz;
  logic [3:0]  an_lz, an_nolz;
  logic        tick_lz, tick_nolz;

  int n_tests;
  int n_fail;

  // One entry per frame: up to two loads issued during the frame and the
  // expected per-digit seg values of the frame itself (digit3 in MSB byte).
  typedef struct {
    int          j0;
    logic [15:0] v0;
    logic [3:0]  d0;
    int          j1;
    logic [15:0] v1;
    logic [3:0]  d1;
    logic [31:0] exp_lz;
    logic [31:0] exp_nolz;
  } vec_t;

  vec_t tbl [NVEC];

  seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg_lz),
    .an         (an_lz),
    .frame_tick (tick_lz)
  );

  seg7_scan_driver #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK), .LZ_SUPPRESS(0)) dut_nolz (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg_nolz),
    .an         (an_nolz),
    .frame_tick (tick_nolz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, " seg_lz"},   {24'h0, seg_lz},    32'hFF);
    chk({tag, " seg_nolz"}, {24'h0, seg_nolz},  32'hFF);
    chk({tag, " an_lz"},    {28'h0, an_lz},     32'hF);
    chk({tag, " an_nolz"},  {28'h0, an_nolz},   32'hF);
    chk({tag, " tick_lz"},  {31'h0, tick_lz},   32'h0);
    chk({tag, " tick_nolz"},{31'h0, tick_nolz}, 32'h0);
  endtask

  // Entered at the negedge whose outputs reflect frame cycle 0 of frame f.
  task automatic check_frame(input int f);
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [7:0] exp_l, exp_n;
    int s, off;
    one = 4'b0001;
    for (int j = 0; j < 32; j++) begin
      s   = j / 8;
      off = j % 8;
      if (off < BLK) begin
        exp_an = 4'hF;
        exp_l  = 8'hFF;
        exp_n  = 8'hFF;
      end else begin
        exp_an = ~(one << s);
        exp_l  = tbl[f].exp_lz[s*8 +: 8];
        exp_n  = tbl[f].exp_nolz[s*8 +: 8];
      end
      chk($sformatf("f%0d j%0d seg_lz", f, j),   {24'h0, seg_lz},   {24'h0, exp_l});
      chk($sformatf("f%0d j%0d seg_nolz", f, j), {24'h0, seg_nolz}, {24'h0, exp_n});
      chk($sformatf("f%0d j%0d an_lz", f, j),    {28'h0, an_lz},    {28'h0, exp_an});
      chk($sformatf("f%0d j%0d an_nolz", f, j),  {28'h0, an_nolz},  {28'h0, exp_an});
      chk($sformatf("f%0d j%0d tick_lz", f, j),  {31'h0, tick_lz},  {31'h0, (j == 30)});
      chk($sformatf("f%0d j%0d tick_nolz", f, j), {31'h0, tick_nolz}, {31'h0, (j == 30)});
      if (j == tbl[f].j0) begin
        load = 1'b1; value_in = tbl[f].v0; dp_in = tbl[f].d0;
      end else if (j == tbl[f].j1) begin
        load = 1'b1; value_in = tbl[f].v1; dp_in = tbl[f].d1;
      end else begin
        load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0;
    dp_in    = 4'h0;

    tbl[0] = '{12, 16'h12AF, 4'b0100, -1, 16'h0, 4'h0, 32'hFFFFFFC0, 32'hC0C0C0C0};
    tbl[1] = '{12, 16'h0005, 4'b0000, -1, 16'h0, 4'h0, 32'hF924888E, 32'hF924888E};
    tbl[2] = '{ 5, 16'h1111, 4'b0000, 20, 16'h2222, 4'h0, 32'hFFFFFF92, 32'hC0C0C092};
    tbl[3] = '{30, 16'h3333, 4'b0000, -1, 16'h0, 4'h0, 32'hA4A4A4A4, 32'hA4A4A4A4};
    tbl[4] = '{12, 16'h00E0, 4'b1111, -1, 16'h0, 4'h0, 32'hB0B0B0B0, 32'hB0B0B0B0};
    tbl[5] = '{12, 16'h0B0D, 4'b0000, -1, 16'h0, 4'h0, 32'h7F7F0640, 32'h40400640};
    tbl[6] = '{-1, 16'h0,    4'b0000, -1, 16'h0, 4'h0, 32'hFF83C0A1, 32'hC083C0A1};
    tbl[7] = '{-1, 16'h0,    4'b0000, -1, 16'h0, 4'h0, 32'hFFFFFFC0, 32'hC0C0C0C0};
    tbl[8] = '{-1, 16'h0,    4'b0000, -1, 16'h0, 4'h0, 32'hFFFFFFC0, 32'hC0C0C0C0};

    repeat (3) @(negedge clk);
    chk_off("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int f = 0; f < NVEC; f++) begin
      check_frame(f);
      if (f == 6) begin
        // Mid-frame reset during digit 2 with a load still pending.
        repeat (19) @(negedge clk);
        chk("pre_rst an_lz",  {28'h0, an_lz},  32'hB);
        chk("pre_rst seg_lz", {24'h0, seg_lz}, 32'h83);
        load = 1'b1; value_in = 16'h7777; dp_in = 4'hF;
        @(negedge clk);
        load = 1'b0; value_in = 16'h0; dp_in = 4'h0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_off("async_rst");
        repeat (2) @(negedge clk);
        chk_off("held_rst");
        rst_n = 1'b1;
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the Nexys3 demo counter/LED logic: time-multiplexes a 16-bit hex value onto the board's 4-digit common-anode 7-segment display. It drives the `seg` and `an` pins, which are currently tied off.
- Values enter through a double-buffered load, so the display never tears mid-frame.
- Leading zeros are suppressed as an option.
- A guard interval with all anodes off separates digits, to prevent ghosting.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV.
- LZ_SUPPRESS, 1: 1 = blank leading zero digits; 0 = show all four digits.

Ports:
- clk, input, 1: system clock (100 MHz on board).
- rst_n, input, 1: asynchronous, active-low reset.
- value_in, input, 16: hex value to display. Digit k = value_in[4k+3:4k]; digit 0 is rightmost.
- dp_in, input, 4: decimal point per digit, 1 = lit. Captured together with value_in.
- load, input, 1: single-cycle strobe that captures value_in/dp_in into the pending register.
- seg, output, 8: cathodes, active-low. seg[7] = dp; seg[6:0] = g,f,e,d,c,b,a.
- an, output, 4: anodes, active-low. an[k] enables digit k.
- frame_tick, output, 1: one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset (asynchronous, rst_n = 0): the following take their reset values immediately:
  - seg = 8'hFF, an = 4'hF, frame_tick = 0
  - prescaler = 0, digit index = 0
  - pending and display registers = 0, pending_valid = 0
- After reset release, digit 0 is the first slot.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. At the terminal count the digit index advances 0→1→2→3→0.
- Slot timing (prescaler value p within the current slot):
  - p < BLANK_CYCLES: an = 4'hF and seg = 8'hFF.
  - p >= BLANK_CYCLES: an has only bit [index] low, and seg shows the decoded digit.
- Output registration: all outputs are registered, so seg/an change one cycle after the prescaler value that selects them.
- Load:
  - load = 1 captures value_in/dp_in into the pending register and sets pending_valid.
  - A later load before the frame boundary overwrites the pending value; last load wins.
- Frame boundary (index 3→0 at the prescaler terminal count):
  - If pending_valid, copy pending into the display register and clear pending_valid.
  - frame_tick = 1 for exactly that cycle.
- Load in the same cycle as the boundary: value_in/dp_in go directly into the display register. pending_valid ends at 0.
- Decode (seg[6:0], active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Leading-zero suppression (LZ_SUPPRESS = 1):
  - Digit k (k = 3..1) is blanked (seg[6:0] = 7'h7F) when display nibbles k..3 are all zero.
  - Digit 0 is never blanked.
  - dp is still driven from dp_in[k] on blanked digits.
- dp: seg[7] = ~dp[k] of the display register.
- Reset mid-frame: the block restarts at digit 0 with blanked outputs. Any pending load is discarded.

Decomposition:
- Shared package seg7_pkg:
  - 16-entry hex→segment constant table
  - SEG_OFF = 8'hFF and AN_OFF = 4'hF
  - digit index typedef (2-bit)
- Sub-module: hex_to_seg7, a combinational nibble → 7-bit decoder using the package table. It is reused by later display blocks.
- Top level holds the prescaler, scan index, double buffer, LZ logic and output registers.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2):
- Reset release, then 40 cycles, no load → display = 0, so digits 3..1 show seg = FF and digit 0 shows seg = 8'hC0. The an sequence per slot is F,F then E/D/B/7 in order. frame_tick pulses every 32 cycles.
- load value_in = 16'h12AF, dp_in = 4'b0100 mid-frame → the display stays at the old value until the next frame_tick. Then the frame shows, with an asserted in turn:
  - an = E: seg = 8'h8E
  - an = D: seg = 8'h88
  - an = B: seg = 8'h24 (dp lit)
  - an = 7: seg = 8'hF9
- load 16'h0005 with LZ_SUPPRESS = 1 → only digit 0 shows 8'h92; digits 1–3 show 8'hFF with their anodes still cycling. With LZ_SUPPRESS = 0 → digits 1–3 show 8'hC0.
- Two loads in one frame (16'h1111, then 16'h2222) → the next frame shows 2222 only. Load coincident with frame_tick (16'h3333) → 3333 is shown in the frame that starts that cycle.
- Assert rst_n = 0 during digit 2 after a pending load → seg/an go to FF/F asynchronously. After release the scan starts at digit 0 and the display = 0, with the pending load lost.
- Every slot: first 2 cycles have an = F; there is never more than one anode low; there is no cycle where an changes without seg being blank in between.
